// File: rtl/alu_fpga_pkg.sv
// -----------------------------------------------------------------------------
// alu_fpga_pkg
// Shared types and constants for the board-level ALU controller: FSM state
// encoding, display-mode encoding, push-button index assignments and the
// active-low seven-segment table (segment order {g,f,e,d,c,b,a}).
// -----------------------------------------------------------------------------
package alu_fpga_pkg;

    localparam int ALUOP_W  = 4;
    localparam int NUM_KEYS = 4;

    // Push-button roles (bit index into KEY)
    localparam int KEY_LOAD_A = 0;
    localparam int KEY_LOAD_B = 1;
    localparam int KEY_EXEC   = 2;
    localparam int KEY_DISP   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DISP_RESULT = 2'd0,
        DISP_A      = 2'd1,
        DISP_B      = 2'd2,
        DISP_OP     = 2'd3
    } disp_mode_e;

    // Entry n is the active-low pattern for hex digit n; entry 15 is leftmost.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/alu_fpga_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_fpga_ctrl_if
// Bus between the controller and the external ALU.
//   port_a, port_b : operands          (controller -> ALU)
//   aluop          : opcode            (controller -> ALU)
//   port_out       : result            (ALU -> controller)
//   negative, overflow, zero : flags   (ALU -> controller)
// master = controller side, slave = ALU side.
// -----------------------------------------------------------------------------
interface alu_fpga_ctrl_if
    import alu_fpga_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]  port_a;
    logic [DATA_W-1:0]  port_b;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  port_out;
    logic               negative;
    logic               overflow;
    logic               zero;

    modport master (
        output port_a, port_b, aluop,
        input  port_out, negative, overflow, zero
    );

    modport slave (
        input  port_a, port_b, aluop,
        output port_out, negative, overflow, zero
    );
endinterface

// File: rtl/alu_fpga_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One raw active-low push button: 2-flop synchroniser, debouncer and press
// pulse generator.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   key_b_i  : raw button, low = pressed
//   press_o  : one-cycle pulse when the debounced level falls (press only)
// A new level is accepted after DB_CYCLES consecutive synchronised samples
// that differ from the current debounced level.
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_b_i,
    output logic press_o
);

    localparam int             CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter resets to 0 but is reloaded on the first cycle after reset:
    // the synchroniser is preset to the released level, so it agrees with
    // level_q until a real press has propagated through both flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_b_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = CNT_LOAD;
        if (sync2_q != level_q) begin
            if (cnt_q == '0) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_fpga_ctrl.sv
// -----------------------------------------------------------------------------
// alu_fpga_ctrl
// Front-panel controller for an external ALU: operands are loaded a switch
// slice at a time, an execute button sequences one ALU operation and captures
// the result and flags, and a display button cycles what the eight
// seven-segment digits show.
//   CLOCK_50  : system clock          RST      : sync active-high reset
//   KEY[3:0]  : raw active-low buttons (load A, load B, execute, display)
//   sw_data   : operand slice value   sw_slice : target slice for loads
//   sw_op     : opcode for execute
//   alu       : ALU bus (operands/opcode out, result/flags in)
//   LEDR      : [2:0] flags {neg,ovf,zero}, [4:3] display mode, [5] busy
//   HEX7..0   : active-low digits of the selected value, HEX7 most significant
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting; loads and execute accepted
// ST_EXEC    | one cycle for the ALU to settle on the new opcode
// ST_CAPTURE | latch port_out and flags, then return to idle
// -----------------------------------------------------------------------------
module alu_fpga_ctrl
    import alu_fpga_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  SW_W       = 16,
    parameter int  DB_CYCLES  = 1000000,
    localparam int NUM_SLICES = DATA_W / SW_W,
    localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic               CLOCK_50,
    input  logic               RST,
    input  logic [3:0]         KEY,
    input  logic [SW_W-1:0]    sw_data,
    input  logic [SLICE_W-1:0] sw_slice,
    input  logic [ALUOP_W-1:0] sw_op,
    alu_fpga_ctrl_if.master    alu,
    output logic [17:0]        LEDR,
    output logic [6:0]         HEX7,
    output logic [6:0]         HEX6,
    output logic [6:0]         HEX5,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX0
);

    logic [NUM_KEYS-1:0] press;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_key_debounce (
            .clk_i   (CLOCK_50),
            .rst_i   (RST),
            .key_b_i (KEY[k]),
            .press_o (press[k])
        );
    end

    state_e             state_q, state_d;
    disp_mode_e         mode_q, mode_d;
    logic [DATA_W-1:0]  port_a_q, port_a_d;
    logic [DATA_W-1:0]  port_b_q, port_b_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [2:0]         flags_q, flags_d;
    logic               loads_ok;
    logic               busy;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            mode_q   <= DISP_RESULT;
            port_a_q <= '0;
            port_b_q <= '0;
            result_q <= '0;
            aluop_q  <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
            result_q <= result_d;
            aluop_q  <= aluop_d;
            flags_q  <= flags_d;
        end
    end

    // An execute press in idle wins over any load press in the same cycle,
    // so the operands the ALU sees are exactly those present at the press.
    assign loads_ok = (state_q == ST_IDLE) && !press[KEY_EXEC];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        port_a_d = port_a_q;
        port_b_d = port_b_q;
        result_d = result_q;
        aluop_d  = aluop_q;
        flags_d  = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (press[KEY_EXEC]) begin
                    state_d = ST_EXEC;
                    aluop_d = sw_op;
                end
            end
            ST_EXEC: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                result_d = alu.port_out;
                flags_d  = {alu.negative, alu.overflow, alu.zero};
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Slice indices past the last slice match no iteration and are ignored.
        if (loads_ok) begin
            for (int s = 0; s < NUM_SLICES; s++) begin
                if (int'(sw_slice) == s) begin
                    if (press[KEY_LOAD_A]) begin
                        port_a_d[s*SW_W +: SW_W] = sw_data;
                    end
                    if (press[KEY_LOAD_B]) begin
                        port_b_d[s*SW_W +: SW_W] = sw_data;
                    end
                end
            end
        end

        if (press[KEY_DISP]) begin
            mode_d = disp_mode_e'(mode_q + 2'd1);
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign alu.port_a = port_a_q;
    assign alu.port_b = port_b_q;
    assign alu.aluop  = aluop_q;

    logic [31:0] disp_val;

    always_comb begin
        disp_val = '0;
        case (mode_q)
            DISP_RESULT: disp_val[DATA_W-1:0]  = result_q;
            DISP_A:      disp_val[DATA_W-1:0]  = port_a_q;
            DISP_B:      disp_val[DATA_W-1:0]  = port_b_q;
            DISP_OP:     disp_val[ALUOP_W-1:0] = aluop_q;
            default:     disp_val              = '0;
        endcase
    end

    assign LEDR = {12'd0, busy, mode_q, flags_q};

    assign HEX0 = hex_seg(disp_val[3:0]);
    assign HEX1 = hex_seg(disp_val[7:4]);
    assign HEX2 = hex_seg(disp_val[11:8]);
    assign HEX3 = hex_seg(disp_val[15:12]);
    assign HEX4 = hex_seg(disp_val[19:16]);
    assign HEX5 = hex_seg(disp_val[23:20]);
    assign HEX6 = hex_seg(disp_val[27:24]);
    assign HEX7 = hex_seg(disp_val[31:28]);

endmodule

// File: tb/tb_alu_fpga_ctrl.sv
module tb_alu_fpga_ctrl;

    localparam int DATA_W = 32;
    localparam int SW_W   = 16;
    localparam int DB     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [15:0] sw_data;
    logic [0:0]  sw_slice;
    logic [3:0]  sw_op;
    logic [17:0] ledr;
    logic [6:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
    logic [55:0] hex_all;

    always #5 clk = ~clk;

    alu_fpga_ctrl_if #(.DATA_W(DATA_W)) alu_bus ();

    alu_fpga_ctrl #(
        .DATA_W    (DATA_W),
        .SW_W      (SW_W),
        .DB_CYCLES (DB)
    ) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .KEY      (key),
        .sw_data  (sw_data),
        .sw_slice (sw_slice),
        .sw_op    (sw_op),
        .alu      (alu_bus),
        .LEDR     (ledr),
        .HEX7     (hex7),
        .HEX6     (hex6),
        .HEX5     (hex5),
        .HEX4     (hex4),
        .HEX3     (hex3),
        .HEX2     (hex2),
        .HEX1     (hex1),
        .HEX0     (hex0)
    );

    assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    int n_chk = 0;
    int n_err = 0;

    // Reference model state (what the panel should hold)
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    logic [2:0]  m_flags;
    int          m_mode;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] hex_of(input logic [31:0] v);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[i*7 +: 7] = seg(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] m_disp();
        case (m_mode)
            0:       return m_res;
            1:       return m_a;
            2:       return m_b;
            default: return {28'd0, m_op};
        endcase
    endfunction

    function automatic logic [17:0] m_ledr(input logic busy);
        logic [1:0] md;
        md = m_mode[1:0];
        return {12'd0, busy, md, m_flags};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx);
        key[idx] = 1'b0;
        tick(10);
        key[idx] = 1'b1;
        tick(12);
    endtask

    task automatic model_load(input int idx, input int slice, input logic [15:0] d);
        if (slice < DATA_W / SW_W) begin
            if (idx == 0) m_a[slice*16 +: 16] = d;
            else          m_b[slice*16 +: 16] = d;
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_flags = '0; m_mode = 0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; key = 4'hF; sw_data = '0; sw_slice = '0; sw_op = '0;
        alu_bus.port_out = '0; alu_bus.negative = 0; alu_bus.overflow = 0; alu_bus.zero = 0;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(1);
        n_chk++; if (alu_bus.port_a !== 32'd0) begin n_err++; $display("FAIL reset_port_a: got %h want 0", alu_bus.port_a); end
        n_chk++; if (alu_bus.port_b !== 32'd0) begin n_err++; $display("FAIL reset_port_b: got %h want 0", alu_bus.port_b); end
        n_chk++; if (alu_bus.aluop !== 4'd0) begin n_err++; $display("FAIL reset_aluop: got %h want 0", alu_bus.aluop); end
        n_chk++; if (ledr !== 18'd0) begin n_err++; $display("FAIL reset_ledr: got %h want 0", ledr); end
        n_chk++; if (hex_all !== hex_of(32'd0)) begin n_err++; $display("FAIL reset_hex: got %h want %h", hex_all, hex_of(32'd0)); end
        tick(15);
        n_chk++; if (alu_bus.port_a !== 32'd0 || ledr !== 18'd0) begin
            n_err++; $display("FAIL reset_exit_quiet: port_a %h ledr %h want 0/0", alu_bus.port_a, ledr); end
    endtask

    task automatic test_load_slices();
        sw_slice = 1'b1; sw_data = 16'hDEAD; press(0);
        sw_slice = 1'b0; sw_data = 16'hBEEF; press(0);
        model_load(0, 1, 16'hDEAD); model_load(0, 0, 16'hBEEF);
        n_chk++; if (alu_bus.port_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_deadbeef: got %h want DEADBEEF", alu_bus.port_a); end
        for (int i = 0; i < 8; i++) begin
            int k, s;
            logic [15:0] d;
            k = $urandom_range(0, 1); s = $urandom_range(0, 1); d = 16'($urandom);
            sw_slice = 1'(s); sw_data = d;
            press(k);
            model_load(k, s, d);
            n_chk++; if (alu_bus.port_a !== m_a) begin n_err++; $display("FAIL load_rand_a[%0d]: got %h want %h", i, alu_bus.port_a, m_a); end
            n_chk++; if (alu_bus.port_b !== m_b) begin n_err++; $display("FAIL load_rand_b[%0d]: got %h want %h", i, alu_bus.port_b, m_b); end
            n_chk++; if (alu_bus.aluop !== m_op) begin n_err++; $display("FAIL load_aluop_stable[%0d]: got %h want %h", i, alu_bus.aluop, m_op); end
        end
    endtask

    task automatic test_execute_timing();
        int w;
        sw_slice = 1'b0; sw_data = 16'd5; press(0);
        sw_slice = 1'b1; sw_data = 16'd0; press(0);
        sw_slice = 1'b0; sw_data = 16'd3; press(1);
        sw_slice = 1'b1; sw_data = 16'd0; press(1);
        m_a = 32'd5; m_b = 32'd3;
        sw_op = 4'h1;
        alu_bus.port_out = 32'd8; alu_bus.negative = 0; alu_bus.overflow = 0; alu_bus.zero = 0;
        key[2] = 1'b0;
        w = 0;
        while (!ledr[5] && w < 30) begin tick(1); w++; end
        n_chk++;
        if (w >= 30) begin
            n_err++; $display("FAIL exec_busy_timeout: busy %b want 1 within 30 cycles", ledr[5]);
        end else begin
            n_chk++; if (hex_all !== hex_of(m_disp())) begin n_err++; $display("FAIL exec_early_result: got %h want %h", hex_all, hex_of(m_disp())); end
            n_chk++; if (alu_bus.aluop !== 4'h1) begin n_err++; $display("FAIL exec_aluop_latch: got %h want 1", alu_bus.aluop); end
            tick(1);
            n_chk++; if (ledr[5] !== 1'b1) begin n_err++; $display("FAIL exec_busy_2nd: got %b want 1", ledr[5]); end
            n_chk++; if (hex_all !== hex_of(m_disp())) begin n_err++; $display("FAIL exec_result_cycle2: got %h want %h", hex_all, hex_of(m_disp())); end
            tick(1);
            m_res = 32'd8; m_op = 4'h1; m_flags = 3'b000;
            n_chk++; if (ledr !== m_ledr(1'b0)) begin n_err++; $display("FAIL exec_busy_end: ledr %h want %h", ledr, m_ledr(1'b0)); end
            n_chk++; if (hex_all !== hex_of(32'd8)) begin n_err++; $display("FAIL exec_result8: got %h want %h", hex_all, hex_of(32'd8)); end
            n_chk++; if (hex0 !== 7'b0000000) begin n_err++; $display("FAIL exec_hex0_8: got %b want 0000000", hex0); end
        end
        key[2] = 1'b1;
        tick(12);
    endtask

    task automatic test_exec_random();
        for (int i = 0; i < 6; i++) begin
            logic [2:0] fl;
            sw_op = 4'($urandom); fl = 3'($urandom);
            alu_bus.port_out = $urandom;
            {alu_bus.negative, alu_bus.overflow, alu_bus.zero} = fl;
            press(2);
            m_op = sw_op; m_res = alu_bus.port_out; m_flags = fl;
            n_chk++; if (hex_all !== hex_of(m_disp())) begin n_err++; $display("FAIL exec_rand_hex[%0d]: got %h want %h", i, hex_all, hex_of(m_disp())); end
            n_chk++; if (ledr !== m_ledr(1'b0)) begin n_err++; $display("FAIL exec_rand_ledr[%0d]: got %h want %h", i, ledr, m_ledr(1'b0)); end
            n_chk++; if (alu_bus.aluop !== m_op) begin n_err++; $display("FAIL exec_rand_aluop[%0d]: got %h want %h", i, alu_bus.aluop, m_op); end
        end
    endtask

    task automatic test_display();
        for (int i = 0; i < 8; i++) begin
            press(3);
            m_mode = (m_mode + 1) % 4;
            n_chk++; if (ledr[4:3] !== 2'(m_mode)) begin n_err++; $display("FAIL disp_mode[%0d]: got %0d want %0d", i, ledr[4:3], m_mode); end
            n_chk++; if (hex_all !== hex_of(m_disp())) begin n_err++; $display("FAIL disp_hex[%0d]: got %h want %h", i, hex_all, hex_of(m_disp())); end
        end
    endtask

    task automatic test_bounce();
        int changes;
        logic [31:0] prev;
        sw_slice = 1'b0; sw_data = 16'hBEEF; press(0);
        model_load(0, 0, 16'hBEEF);
        for (int c = 0; c < 3; c++) begin
            int expect_ev;
            changes = 0;
            prev = alu_bus.port_a;
            expect_ev = (c == 0) ? 0 : 1;
            for (int i = 0; i < 30; i++) begin
                case (c)
                    0:       key[0] = (i < 3) ? 1'b0 : 1'b1;
                    1:       key[0] = (i < 4) ? 1'b0 : 1'b1;
                    default: key[0] = (i < 2 || (i >= 3 && i < 13)) ? 1'b0 : 1'b1;
                endcase
                sw_data = 16'(16'h1000 * (c + 1) + i);
                tick(1);
                if (alu_bus.port_a !== prev) changes++;
                prev = alu_bus.port_a;
            end
            n_chk++; if (changes !== expect_ev) begin n_err++; $display("FAIL bounce_events[%0d]: got %0d want %0d", c, changes, expect_ev); end
        end
        key[0] = 1'b1;
        sw_data = 16'h5A5A; press(0);
        model_load(0, 0, 16'h5A5A);
        n_chk++; if (alu_bus.port_a !== m_a) begin n_err++; $display("FAIL bounce_resync: got %h want %h", alu_bus.port_a, m_a); end
    endtask

    task automatic test_busy_drop();
        for (int off = 0; off < 4; off++) begin
            int s;
            logic [15:0] d;
            logic [2:0]  fl;
            s = $urandom_range(0, 1);
            d = ~m_a[s*16 +: 16];
            sw_slice = 1'(s); sw_data = d;
            sw_op = 4'($urandom); fl = 3'($urandom);
            alu_bus.port_out = $urandom;
            {alu_bus.negative, alu_bus.overflow, alu_bus.zero} = fl;
            key[2] = 1'b0;
            tick(off);
            key[0] = 1'b0;
            if (off == 1) key[3] = 1'b0;
            tick(10);
            key = 4'hF;
            tick(12);
            m_op = sw_op; m_res = alu_bus.port_out; m_flags = fl;
            if (off >= 3) model_load(0, s, d);
            if (off == 1) m_mode = (m_mode + 1) % 4;
            n_chk++; if (alu_bus.port_a !== m_a) begin n_err++; $display("FAIL drop_port_a[off%0d]: got %h want %h", off, alu_bus.port_a, m_a); end
            n_chk++; if (ledr !== m_ledr(1'b0)) begin n_err++; $display("FAIL drop_ledr[off%0d]: got %h want %h", off, ledr, m_ledr(1'b0)); end
            n_chk++; if (hex_all !== hex_of(m_disp())) begin n_err++; $display("FAIL drop_hex[off%0d]: got %h want %h", off, hex_all, hex_of(m_disp())); end
        end
    endtask

    task automatic test_reset_capture();
        int w;
        sw_op = 4'hC;
        alu_bus.port_out = $urandom | 32'h1;
        {alu_bus.negative, alu_bus.overflow, alu_bus.zero} = 3'b111;
        key[2] = 1'b0;
        w = 0;
        while (!ledr[5] && w < 30) begin tick(1); w++; end
        n_chk++;
        if (w >= 30) begin
            n_err++; $display("FAIL rstcap_busy_timeout: busy %b want 1 within 30 cycles", ledr[5]);
        end
        tick(1);
        rst = 1'b1; key = 4'hF;
        tick(3);
        model_reset();
        n_chk++; if (alu_bus.port_a !== 32'd0 || alu_bus.port_b !== 32'd0 || alu_bus.aluop !== 4'd0) begin
            n_err++; $display("FAIL rstcap_bus: a %h b %h op %h want 0", alu_bus.port_a, alu_bus.port_b, alu_bus.aluop); end
        n_chk++; if (ledr !== 18'd0) begin n_err++; $display("FAIL rstcap_ledr: got %h want 0", ledr); end
        rst = 1'b0;
        tick(12);
        n_chk++; if (hex_all !== hex_of(32'd0)) begin n_err++; $display("FAIL rstcap_result: got %h want %h", hex_all, hex_of(32'd0)); end
        n_chk++; if (ledr !== 18'd0) begin n_err++; $display("FAIL rstcap_idle: got %h want 0", ledr); end
    endtask

    initial begin
        test_reset();
        test_load_slices();
        test_execute_timing();
        test_exec_random();
        test_display();
        test_bounce();
        test_busy_drop();
        test_reset_capture();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
